// File: rtl/unidade_controle_pkg.sv
// State codes and control-bundle type shared by the round controller and the HEX display mux.
package unidade_controle_pkg;

    localparam logic [3:0] INICIAL    = 4'd0;
    localparam logic [3:0] PREPARA    = 4'd1;
    localparam logic [3:0] CARREGA_A  = 4'd2;
    localparam logic [3:0] CARREGA_B  = 4'd3;
    localparam logic [3:0] ESPERA     = 4'd4;
    localparam logic [3:0] REGISTRA   = 4'd5;
    localparam logic [3:0] COMPARA    = 4'd6;
    localparam logic [3:0] ACERTO     = 4'd7;
    localparam logic [3:0] PROXIMA    = 4'd8;
    localparam logic [3:0] PISCA_ON   = 4'd9;
    localparam logic [3:0] PISCA_OFF  = 4'd10;
    localparam logic [3:0] FIM_GANHOU = 4'd11;
    localparam logic [3:0] FIM_PERDEU = 4'd12;

    typedef struct packed {
        logic zeraT;
        logic zeraS;
        logic zeraA;
        logic zeraR;
        logic zeraL;
        logic contaS;
        logic contaA;
        logic registraA;
        logic registraR;
        logic registraL;
        logic contaLedsOn;
        logic contaLedsOff;
        logic contaPiscadas;
        logic apagarAcertos;
        logic pronto;
        logic ganhou;
        logic perdeu;
    } controle_t;

    // Pressing the same button that scored last time is not a new hit.
    function automatic logic jogada_acertada(logic acertou, logic repetida, logic sem_anterior);
        return acertou & ~(repetida & ~sem_anterior);
    endfunction

endpackage

// File: rtl/unidade_controle_if.sv
// Control/status bundle between unidade_controle (master) and fluxo_dados (slave).
interface unidade_controle_if;

    logic       iniciar;
    logic       tem_jogada;
    logic       timeout;
    logic       acertouJogada;
    logic       jogadaAtualEQUALSacertoAnterior;
    logic       acertoAnteriorEQUALSzero;
    logic       fimS;
    logic       fimLedsOn;
    logic       fimLedsOff;
    logic       fimPiscaLeds;

    logic       zeraT;
    logic       zeraS;
    logic       zeraA;
    logic       zeraR;
    logic       zeraL;
    logic       contaS;
    logic       contaA;
    logic       registraA;
    logic       registraR;
    logic       registraL;
    logic       contaLedsOn;
    logic       contaLedsOff;
    logic       contaPiscadas;
    logic       apagarAcertos;
    logic       pronto;
    logic       ganhou;
    logic       perdeu;
    logic [3:0] db_estado;

    modport master (
        input  iniciar, tem_jogada, timeout, acertouJogada,
               jogadaAtualEQUALSacertoAnterior, acertoAnteriorEQUALSzero,
               fimS, fimLedsOn, fimLedsOff, fimPiscaLeds,
        output zeraT, zeraS, zeraA, zeraR, zeraL, contaS, contaA, registraA,
               registraR, registraL, contaLedsOn, contaLedsOff, contaPiscadas,
               apagarAcertos, pronto, ganhou, perdeu, db_estado
    );

    modport slave (
        output iniciar, tem_jogada, timeout, acertouJogada,
               jogadaAtualEQUALSacertoAnterior, acertoAnteriorEQUALSzero,
               fimS, fimLedsOn, fimLedsOff, fimPiscaLeds,
        input  zeraT, zeraS, zeraA, zeraR, zeraL, contaS, contaA, registraA,
               registraR, registraL, contaLedsOn, contaLedsOff, contaPiscadas,
               apagarAcertos, pronto, ganhou, perdeu, db_estado
    );

endinterface

// File: rtl/unidade_controle.sv
// Moore FSM sequencing fluxo_dados through one game round: load, wait for press, score,
// optional win blink, and final ganhou/perdeu report.
module unidade_controle
    import unidade_controle_pkg::*;
#(
    parameter bit MISS_IS_LOSS = 1'b0,
    parameter bit PISCA_EN     = 1'b1
) (
    input  logic               clock,
    input  logic               reset,
    unidade_controle_if.master uc
);

    logic [3:0] estado;
    logic [3:0] proximo;
    controle_t  ctrl;
    logic       acerto;

    assign acerto = jogada_acertada(uc.acertouJogada,
                                    uc.jogadaAtualEQUALSacertoAnterior,
                                    uc.acertoAnteriorEQUALSzero);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) estado <= INICIAL;
        else        estado <= proximo;
    end

    always_comb begin
        proximo = INICIAL;
        case (estado)
            INICIAL:   proximo = uc.iniciar ? PREPARA : INICIAL;
            PREPARA:   proximo = CARREGA_A;
            CARREGA_A: proximo = CARREGA_B;
            CARREGA_B: proximo = ESPERA;
            ESPERA: begin
                if (uc.tem_jogada)   proximo = REGISTRA;
                else if (uc.timeout) proximo = FIM_PERDEU;
                else                 proximo = ESPERA;
            end
            REGISTRA:  proximo = COMPARA;
            COMPARA: begin
                if (acerto)            proximo = ACERTO;
                else if (MISS_IS_LOSS) proximo = FIM_PERDEU;
                else                   proximo = PROXIMA;
            end
            ACERTO:    proximo = PROXIMA;
            PROXIMA: begin
                if (!uc.fimS)     proximo = CARREGA_A;
                else if (PISCA_EN) proximo = PISCA_ON;
                else              proximo = FIM_GANHOU;
            end
            PISCA_ON:  proximo = uc.fimLedsOn ? PISCA_OFF : PISCA_ON;
            PISCA_OFF: begin
                if (!uc.fimLedsOff)     proximo = PISCA_OFF;
                else if (uc.fimPiscaLeds) proximo = FIM_GANHOU;
                else                    proximo = PISCA_ON;
            end
            FIM_GANHOU: proximo = uc.iniciar ? PREPARA : FIM_GANHOU;
            FIM_PERDEU: proximo = uc.iniciar ? PREPARA : FIM_PERDEU;
            default:    proximo = INICIAL;
        endcase
    end

    // contaS is a pure Moore output of PROXIMA; the sequence counter is cleared in PREPARA anyway.
    always_comb begin
        ctrl = '0;
        case (estado)
            INICIAL:   ctrl.pronto = 1'b1;
            PREPARA: begin
                ctrl.zeraS = 1'b1;
                ctrl.zeraA = 1'b1;
                ctrl.zeraR = 1'b1;
                ctrl.zeraL = 1'b1;
                ctrl.zeraT = 1'b1;
            end
            CARREGA_B: begin
                ctrl.registraL = 1'b1;
                ctrl.zeraT     = 1'b1;
            end
            REGISTRA:  ctrl.registraR = 1'b1;
            ACERTO: begin
                ctrl.contaA    = 1'b1;
                ctrl.registraA = 1'b1;
            end
            PROXIMA: begin
                ctrl.zeraR  = 1'b1;
                ctrl.contaS = 1'b1;
            end
            PISCA_ON:  ctrl.contaLedsOn = 1'b1;
            PISCA_OFF: begin
                ctrl.contaLedsOff  = 1'b1;
                ctrl.contaPiscadas = 1'b1;
                ctrl.apagarAcertos = 1'b1;
            end
            FIM_GANHOU: begin
                ctrl.pronto = 1'b1;
                ctrl.ganhou = 1'b1;
            end
            FIM_PERDEU: begin
                ctrl.pronto = 1'b1;
                ctrl.perdeu = 1'b1;
            end
            default:   ctrl = '0;
        endcase
    end

    assign uc.zeraT         = ctrl.zeraT;
    assign uc.zeraS         = ctrl.zeraS;
    assign uc.zeraA         = ctrl.zeraA;
    assign uc.zeraR         = ctrl.zeraR;
    assign uc.zeraL         = ctrl.zeraL;
    assign uc.contaS        = ctrl.contaS;
    assign uc.contaA        = ctrl.contaA;
    assign uc.registraA     = ctrl.registraA;
    assign uc.registraR     = ctrl.registraR;
    assign uc.registraL     = ctrl.registraL;
    assign uc.contaLedsOn   = ctrl.contaLedsOn;
    assign uc.contaLedsOff  = ctrl.contaLedsOff;
    assign uc.contaPiscadas = ctrl.contaPiscadas;
    assign uc.apagarAcertos = ctrl.apagarAcertos;
    assign uc.pronto        = ctrl.pronto;
    assign uc.ganhou        = ctrl.ganhou;
    assign uc.perdeu        = ctrl.perdeu;
    assign uc.db_estado     = estado;

endmodule

// File: tb/tb_unidade_controle.sv
// Random-stimulus scoreboard bench for unidade_controle in two parameter configurations.
module tb_unidade_controle;

    localparam int N_CICLOS = 3000;

    // Output vector bit positions, MSB first.
    localparam int O_ZERAT = 16, O_ZERAS = 15, O_ZERAA = 14, O_ZERAR = 13, O_ZERAL = 12;
    localparam int O_CONTAS = 11, O_CONTAA = 10, O_REGA = 9, O_REGR = 8, O_REGL = 7;
    localparam int O_LEDON = 6, O_LEDOFF = 5, O_PISC = 4, O_APAGA = 3;
    localparam int O_PRONTO = 2, O_GANHOU = 1, O_PERDEU = 0;

    typedef struct packed {
        bit iniciar;
        bit tem;
        bit tmo;
        bit acertou;
        bit repetida;
        bit sem_anterior;
        bit fim_s;
        bit fim_on;
        bit fim_off;
        bit fim_pisca;
    } entrada_t;

    typedef struct {
        int sa;
        int sb;
    } esperado_t;

    logic     clock = 1'b0;
    logic     reset;
    entrada_t ent;
    int       checks = 0;
    int       errors = 0;

    esperado_t fila[$];

    unidade_controle_if ifa ();
    unidade_controle_if ifb ();

    always #5 clock = ~clock;

    assign ifa.iniciar = ent.iniciar;
    assign ifa.tem_jogada = ent.tem;
    assign ifa.timeout = ent.tmo;
    assign ifa.acertouJogada = ent.acertou;
    assign ifa.jogadaAtualEQUALSacertoAnterior = ent.repetida;
    assign ifa.acertoAnteriorEQUALSzero = ent.sem_anterior;
    assign ifa.fimS = ent.fim_s;
    assign ifa.fimLedsOn = ent.fim_on;
    assign ifa.fimLedsOff = ent.fim_off;
    assign ifa.fimPiscaLeds = ent.fim_pisca;

    assign ifb.iniciar = ent.iniciar;
    assign ifb.tem_jogada = ent.tem;
    assign ifb.timeout = ent.tmo;
    assign ifb.acertouJogada = ent.acertou;
    assign ifb.jogadaAtualEQUALSacertoAnterior = ent.repetida;
    assign ifb.acertoAnteriorEQUALSzero = ent.sem_anterior;
    assign ifb.fimS = ent.fim_s;
    assign ifb.fimLedsOn = ent.fim_on;
    assign ifb.fimLedsOff = ent.fim_off;
    assign ifb.fimPiscaLeds = ent.fim_pisca;

    unidade_controle #(.MISS_IS_LOSS(1'b0), .PISCA_EN(1'b1)) dut_a (
        .clock(clock), .reset(reset), .uc(ifa)
    );
    unidade_controle #(.MISS_IS_LOSS(1'b1), .PISCA_EN(1'b0)) dut_b (
        .clock(clock), .reset(reset), .uc(ifb)
    );

    logic [16:0] saidas_a;
    logic [16:0] saidas_b;

    assign saidas_a = {ifa.zeraT, ifa.zeraS, ifa.zeraA, ifa.zeraR, ifa.zeraL, ifa.contaS,
                       ifa.contaA, ifa.registraA, ifa.registraR, ifa.registraL,
                       ifa.contaLedsOn, ifa.contaLedsOff, ifa.contaPiscadas,
                       ifa.apagarAcertos, ifa.pronto, ifa.ganhou, ifa.perdeu};
    assign saidas_b = {ifb.zeraT, ifb.zeraS, ifb.zeraA, ifb.zeraR, ifb.zeraL, ifb.contaS,
                       ifb.contaA, ifb.registraA, ifb.registraR, ifb.registraL,
                       ifb.contaLedsOn, ifb.contaLedsOff, ifb.contaPiscadas,
                       ifb.apagarAcertos, ifb.pronto, ifb.ganhou, ifb.perdeu};

    // Reference round behaviour, state numbered as on the HEX display.
    function automatic int modelo_proximo(int st, entrada_t e, bit perde_no_erro, bit pisca);
        bit acerto;
        acerto = e.acertou && !(e.repetida && !e.sem_anterior);
        if (st == 0)  return e.iniciar ? 1 : 0;
        if (st == 1)  return 2;
        if (st == 2)  return 3;
        if (st == 3)  return 4;
        if (st == 4)  return e.tem ? 5 : (e.tmo ? 12 : 4);
        if (st == 5)  return 6;
        if (st == 6)  return acerto ? 7 : (perde_no_erro ? 12 : 8);
        if (st == 7)  return 8;
        if (st == 8)  return e.fim_s ? (pisca ? 9 : 11) : 2;
        if (st == 9)  return e.fim_on ? 10 : 9;
        if (st == 10) return !e.fim_off ? 10 : (e.fim_pisca ? 11 : 9);
        if (st == 11 || st == 12) return e.iniciar ? 1 : st;
        return 0;
    endfunction

    function automatic logic [16:0] modelo_saidas(int st);
        logic [16:0] o;
        o = '0;
        o[O_ZERAT]  = (st == 1) || (st == 3);
        o[O_ZERAS]  = (st == 1);
        o[O_ZERAA]  = (st == 1);
        o[O_ZERAR]  = (st == 1) || (st == 8);
        o[O_ZERAL]  = (st == 1);
        o[O_CONTAS] = (st == 8);
        o[O_CONTAA] = (st == 7);
        o[O_REGA]   = (st == 7);
        o[O_REGR]   = (st == 5);
        o[O_REGL]   = (st == 3);
        o[O_LEDON]  = (st == 9);
        o[O_LEDOFF] = (st == 10);
        o[O_PISC]   = (st == 10);
        o[O_APAGA]  = (st == 10);
        o[O_PRONTO] = (st == 0) || (st == 11) || (st == 12);
        o[O_GANHOU] = (st == 11);
        o[O_PERDEU] = (st == 12);
        return o;
    endfunction

    task automatic verifica(input string nome, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nome, got, exp, $time);
        end
    endtask

    task automatic verifica_tudo(input string tag, input int sa, input int sb);
        verifica({tag, " estado_a"}, int'(ifa.db_estado), sa);
        verifica({tag, " saidas_a"}, int'(saidas_a), int'(modelo_saidas(sa)));
        verifica({tag, " estado_b"}, int'(ifb.db_estado), sb);
        verifica({tag, " saidas_b"}, int'(saidas_b), int'(modelo_saidas(sb)));
    endtask

    // Monitor: Moore outputs are valid every cycle, checked 1 ns after the edge.
    initial begin
        esperado_t e;
        forever begin
            @(posedge clock);
            #1;
            if (fila.size() > 0) begin
                e = fila.pop_front();
                verifica_tudo("ciclo", e.sa, e.sb);
            end
        end
    end

    initial begin
        int  sa;
        int  sb;
        bit  rst;
        bit  reset_em_espera;
        esperado_t e;

        reset = 1'b0;
        ent = '0;
        sa = 0;
        sb = 0;
        reset_em_espera = 1'b0;
        repeat (2) @(posedge clock);
        #3;
        verifica_tudo("reset_inicial", 0, 0);

        for (int c = 0; c < N_CICLOS; c++) begin
            @(posedge clock);
            #2;
            ent.iniciar      = ($urandom_range(99) < 50);
            ent.tem          = ($urandom_range(99) < 30);
            ent.tmo          = ($urandom_range(99) < 10);
            ent.acertou      = ($urandom_range(99) < 70);
            ent.repetida     = ($urandom_range(99) < 20);
            ent.sem_anterior = ($urandom_range(99) < 60);
            ent.fim_s        = ($urandom_range(99) < 25);
            ent.fim_on       = ($urandom_range(99) < 50);
            ent.fim_off      = ($urandom_range(99) < 50);
            ent.fim_pisca    = ($urandom_range(99) < 40);
            rst = ($urandom_range(63) != 0);
            if (sa == 4 && !reset_em_espera && c > 20) begin
                rst = 1'b0;
                reset_em_espera = 1'b1;
            end
            reset = rst;
            if (!rst) begin
                sa = 0;
                sb = 0;
                #1;
                verifica_tudo("reset_async", 0, 0);
            end else begin
                sa = modelo_proximo(sa, ent, 1'b0, 1'b1);
                sb = modelo_proximo(sb, ent, 1'b1, 1'b0);
            end
            e.sa = sa;
            e.sb = sb;
            fila.push_back(e);
        end

        @(posedge clock);
        #3;
        if (fila.size() != 0) begin
            errors++;
            $display("FAIL fila_pendente: got %0d entries expected 0", fila.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
